// File: rtl/ahb_default_sub.sv
// AHB-Lite default subordinate: answers any selected NONSEQ/SEQ transfer with a two-cycle ERROR.
// Optional first-fault / fault-count log built when DEFAULT_SUB_FAULTLOG_EN is defined.
module ahb_default_sub #(
    parameter int PA_BITS  = 56,
    parameter int CNT_BITS = 8,
    parameter int XLEN     = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                HSELDefault,
    input  logic [PA_BITS-1:0]  HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic                HREADY,
    output logic                HREADYDefault,
    output logic                HRESPDefault,
    output logic [XLEN-1:0]     HRDATADefault,
    input  logic                LogClear,
    output logic                FaultValid,
    output logic [PA_BITS-1:0]  FaultAddr,
    output logic                FaultWrite,
    output logic [2:0]          FaultSize,
    output logic [CNT_BITS-1:0] FaultCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    state_t state_reg;
    logic   hready_reg;
    logic   hresp_reg;
    logic   accept;

    // HTRANS[1] set means NONSEQ or SEQ; IDLE and BUSY get a zero-wait OKAY.
    assign accept = HSELDefault & HREADY & HTRANS[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            hready_reg <= 1'b1;
            hresp_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_reg  <= S_ERR1;
                        hready_reg <= 1'b0;
                        hresp_reg  <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state_reg  <= S_ERR2;
                    hready_reg <= 1'b1;
                    hresp_reg  <= 1'b1;
                end
                S_ERR2: begin
                    if (accept) begin
                        state_reg  <= S_ERR1;
                        hready_reg <= 1'b0;
                        hresp_reg  <= 1'b1;
                    end else begin
                        state_reg  <= S_IDLE;
                        hready_reg <= 1'b1;
                        hresp_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    hready_reg <= 1'b1;
                    hresp_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign HREADYDefault = hready_reg;
    assign HRESPDefault  = hresp_reg;
    assign HRDATADefault = '0;

`ifdef DEFAULT_SUB_FAULTLOG_EN
    logic                fault_valid_reg;
    logic [PA_BITS-1:0]  fault_addr_reg;
    logic                fault_write_reg;
    logic [2:0]          fault_size_reg;
    logic [CNT_BITS-1:0] fault_count_reg;

    // A clear coinciding with a new fault lets the new fault win and restarts the count at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_valid_reg <= 1'b0;
            fault_addr_reg  <= '0;
            fault_write_reg <= 1'b0;
            fault_size_reg  <= '0;
            fault_count_reg <= '0;
        end else if (accept) begin
            if (!fault_valid_reg || LogClear) begin
                fault_addr_reg  <= HADDR;
                fault_write_reg <= HWRITE;
                fault_size_reg  <= HSIZE;
            end
            fault_valid_reg <= 1'b1;
            if (LogClear)
                fault_count_reg <= CNT_BITS'(1);
            else if (fault_count_reg != '1)
                fault_count_reg <= fault_count_reg + CNT_BITS'(1);
        end else if (LogClear) begin
            fault_valid_reg <= 1'b0;
            fault_count_reg <= '0;
        end
    end

    assign FaultValid = fault_valid_reg;
    assign FaultAddr  = fault_addr_reg;
    assign FaultWrite = fault_write_reg;
    assign FaultSize  = fault_size_reg;
    assign FaultCount = fault_count_reg;

    logic unused_inputs;
    assign unused_inputs = HTRANS[0];
`else
    assign FaultValid = 1'b0;
    assign FaultAddr  = '0;
    assign FaultWrite = 1'b0;
    assign FaultSize  = '0;
    assign FaultCount = '0;

    // Address-phase fields and the clear only feed the log.
    logic unused_inputs;
    assign unused_inputs = ^{LogClear, HADDR, HWRITE, HSIZE, HTRANS[0]};
`endif

endmodule
